// File: rtl/fetch_decode_queue_if.sv
// fetch_decode_queue_if: fetch-side enqueue and decode-side dequeue handshakes plus redirect flush.
interface fetch_decode_queue_if;
  logic        enq_valid;
  logic        enq_ready;
  logic [15:0] enq_pc;
  logic [15:0] enq_instr;
  logic        deq_valid;
  logic        deq_ready;
  logic [15:0] deq_pc;
  logic [15:0] deq_npc;
  logic [15:0] deq_instr;
  logic        flush;
  modport master (
    output enq_valid, enq_pc, enq_instr, deq_ready, flush,
    input  enq_ready, deq_valid, deq_pc, deq_npc, deq_instr
  );
  modport slave (
    input  enq_valid, enq_pc, enq_instr, deq_ready, flush,
    output enq_ready, deq_valid, deq_pc, deq_npc, deq_instr
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: LC-3b fetch-to-decode instruction FIFO with redirect flush.
// Define FDQ_BYPASS_EN to pass an enqueue straight to decode when the queue is empty.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fetch_decode_queue_if.slave   bus,
  output logic [CW-1:0]         count
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0]   pc_mem    [DEPTH];
  logic [15:0]   instr_mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          byp;
  logic          enq_fire;
  logic          deq_fire;
`ifdef FDQ_BYPASS_EN
  assign byp = (cnt == '0) && bus.enq_valid;
`else
  assign byp = 1'b0;
`endif
  // enq_ready looks only at occupancy so decode stalls never reach fetch combinationally
  assign bus.enq_ready = cnt != CW'(DEPTH);
  assign bus.deq_valid = ((cnt != '0) || byp) && !bus.flush;
  assign bus.deq_pc    = byp ? bus.enq_pc : pc_mem[rp];
  assign bus.deq_instr = byp ? bus.enq_instr : instr_mem[rp];
  assign bus.deq_npc   = bus.deq_pc + 16'd2;
  assign count         = cnt;
  // a bypassed word consumed in the same cycle is never stored
  assign enq_fire = bus.enq_valid && bus.enq_ready && !bus.flush && !(byp && bus.deq_ready);
  assign deq_fire = bus.deq_valid && bus.deq_ready && !byp;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (enq_fire) begin
        pc_mem[wp]    <= bus.enq_pc;
        instr_mem[wp] <= bus.enq_instr;
        wp            <= wp + AW'(1);
      end
      if (deq_fire) rp <= rp + AW'(1);
      cnt <= cnt + CW'(enq_fire) - CW'(deq_fire);
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: randomized and directed scoreboard bench for fetch_decode_queue.
module tb_fetch_decode_queue;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef FDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] count;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [31:0]   mq [$];
  fetch_decode_queue_if bus();
  fetch_decode_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus), .count(count));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic v, input logic [15:0] pc, input logic [15:0] ins, input logic dr, input logic fl);
    @(posedge clk);
    #1;
    bus.enq_valid = v;
    bus.enq_pc    = pc;
    bus.enq_instr = ins;
    bus.deq_ready = dr;
    bus.flush     = fl;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask
  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
  endtask
  // Scoreboard model: a plain queue of {pc, instr}; outputs checked at negedge
  int          sz;
  bit          mbyp;
  bit          mvalid;
  logic [31:0] hd;
  always @(negedge clk) begin
    if (!reset_n) mq.delete();
    else begin
      sz     = mq.size();
      mbyp   = BYP && sz == 0 && bus.enq_valid;
      mvalid = (sz != 0 || mbyp) && !bus.flush;
      chk("enq_ready", 32'(bus.enq_ready), 32'(sz != DEPTH));
      chk("deq_valid", 32'(bus.deq_valid), 32'(mvalid));
      chk("count", 32'(count), 32'(sz));
      if (mvalid && bus.deq_ready) begin
        hd = mbyp ? {bus.enq_pc, bus.enq_instr} : mq.pop_front();
        chk("deq_pc", 32'(bus.deq_pc), 32'(hd[31:16]));
        chk("deq_instr", 32'(bus.deq_instr), 32'(hd[15:0]));
        chk("deq_npc", 32'(bus.deq_npc), 32'(16'(hd[31:16] + 16'd2)));
      end
      if (bus.flush) mq.delete();
      else if (bus.enq_valid && sz != DEPTH && !(mbyp && bus.deq_ready))
        mq.push_back({bus.enq_pc, bus.enq_instr});
    end
  end
  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_pc    = '0;
    bus.enq_instr = '0;
    bus.deq_ready = 1'b0;
    bus.flush     = 1'b0;
    #1;
    chk("rst_deq_valid", 32'(bus.deq_valid), 0);
    chk("rst_enq_ready", 32'(bus.enq_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_deq_pc", 32'(bus.deq_pc), 0);
    chk("rst_deq_instr", 32'(bus.deq_instr), 0);
    chk("rst_deq_npc", 32'(bus.deq_npc), 32'h2);
    #11 reset_n = 1'b1;
    // fill to full, refused fifth, then ordered drain
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h3000 + 16'(2 * i), 16'hA000 + 16'(i), 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1 chk("full_count", 32'(count), DEPTH);
    chk("full_enq_ready", 32'(bus.enq_ready), 0);
    drain();
    // steady state at cnt=2 across pointer wrap
    for (int i = 0; i < 2; i++) cyc(1'b1, 16'h2000 + 16'(2 * i), 16'hB000 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'h2100 + 16'(2 * i), 16'hC000 + 16'(i), 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1 chk("steady_count", 32'(count), 2);
    drain();
    // flush at cnt=3 with a concurrent enqueue and dequeue request
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h3100 + 16'(2 * i), 16'hD000 + 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'h4000, 16'h4444, 1'b1, 1'b1);
    #1 chk("flush_deq_valid", 32'(bus.deq_valid), 0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    #1 chk("post_flush_count", 32'(count), 0);
    idle(2);
    // npc wrap
    cyc(1'b1, 16'hFFFE, 16'h5555, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    #1 chk("wrap_npc", 32'(bus.deq_npc), 0);
    drain();
    // empty queue with enqueue and ready together: bypass or 1-cycle latency
    cyc(1'b1, 16'h5000, 16'h1234, 1'b1, 1'b0);
    #1 chk("byp_deq_valid", 32'(bus.deq_valid), 32'(BYP));
    cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    #1 chk("byp_next_valid", 32'(bus.deq_valid), 32'(!BYP));
    drain();
    // randomized traffic
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom) & 16'hFFFE, 16'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    // asynchronous reset with three entries held
    drain();
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h6000 + 16'(2 * i), 16'hE000 + 16'(i), 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_deq_valid", 32'(bus.deq_valid), 0);
    chk("arst_enq_ready", 32'(bus.enq_ready), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_deq_npc", 32'(bus.deq_npc), 32'h2);
    chk("arst_deq_pc", 32'(bus.deq_pc), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    idle(2);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
